// File: rtl/ascon_aead_sequencer_pkg.sv
// Shared definitions for the Ascon-128 AEAD sequencer.
//  - Ascon-128 IV and default round counts
//  - bit positions of the five 64-bit words S0..S4 inside the 320-bit state
//    (S0 occupies the most significant word, matching {IV, K, N} at init)
//  - FSM state encodings for the sequencer and the permutation-call handshake
package ascon_aead_sequencer_pkg;

  localparam logic [63:0]  ASCON_IV         = 64'h80400c0600000000;
  localparam int unsigned  ROUNDS_A_DEFAULT = 12;
  localparam int unsigned  ROUNDS_B_DEFAULT = 6;

  localparam int unsigned  STATE_W = 320;
  localparam int unsigned  WORD_W  = 64;

  // Use as s[Sx_MSB -: WORD_W]
  localparam int unsigned  S0_MSB = 319;
  localparam int unsigned  S1_MSB = 255;
  localparam int unsigned  S2_MSB = 191;
  localparam int unsigned  S3_MSB = 127;
  localparam int unsigned  S4_MSB = 63;

  typedef enum logic [3:0] {
    StIdle,
    StInitP,
    StAd,
    StAdP,
    StDsep,
    StMsg,
    StMsgP,
    StFinP,
    StTag
  } aead_state_e;

  typedef enum logic [1:0] {
    PcIdle,
    PcCall,
    PcRel
  } perm_call_state_e;

endpackage

// File: rtl/ascon_aead_sequencer_perm_call.sv
// Start/ready/release handshake towards the shared Ascon permutation core.
//  req         in   level from the sequencer, held until done
//  rnd         in   round count for the pending call
//  s_out       in   state to permute; the sequencer keeps it stable during a call
//  done        out  1-cycle pulse: perm_s_in is valid, sequencer captures s_in
//  s_in        out  permuted state (pass-through of perm_s_in)
//  perm_*      core-side handshake; perm_start is a registered level
// After each call the block waits in PcRel until the core has dropped
// perm_ready, so a lingering ready can never complete the next call early.
module ascon_aead_sequencer_perm_call
  import ascon_aead_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [3:0]           rnd,
  input  logic [STATE_W-1:0]   s_out,
  output logic                 done,
  output logic [STATE_W-1:0]   s_in,
  output logic                 perm_start,
  output logic [3:0]           perm_rnd,
  output logic [STATE_W-1:0]   perm_s_out,
  input  logic                 perm_ready,
  input  logic [STATE_W-1:0]   perm_s_in
);

  perm_call_state_e st_q, st_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= PcIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      PcIdle:  if (req) st_d = PcCall;
      PcCall:  if (perm_ready) st_d = PcRel;
      PcRel:   if (!perm_ready) st_d = req ? PcCall : PcIdle;
      default: st_d = PcIdle;
    endcase
  end

  always_comb begin
    perm_start = (st_q == PcCall);
    done       = perm_start & perm_ready;
    perm_rnd   = perm_start ? rnd : 4'd0;
    perm_s_out = perm_start ? s_out : '0;
    s_in       = perm_s_in;
  end

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Ascon-128 AEAD mode controller. Owns the 320-bit working state, key
// injection, domain separation and tag compute/compare, and sequences the
// shared permutation core (pa for init/finalization, pb per AD block and per
// non-final message block).
//  start/decrypt/no_ad/key/nonce  operation setup, sampled in IDLE on start
//  ad_valid/ad_data/ad_last/ad_ready      associated-data stream (pre-padded)
//  din_valid/din_data/din_last/din_ready  PT/CT stream (pre-padded, >=1 block)
//  dout_valid/dout_data           CT/PT out, pulse the cycle after accept
//  tag_in/tag_valid/tag/auth_ok   tag result, pulse at end of operation
//  busy                           high from start accept until back in IDLE
//  perm_*                         permutation core handshake
module ascon_aead_sequencer
  import ascon_aead_sequencer_pkg::*;
#(
  parameter logic [63:0] IV       = ASCON_IV,
  parameter int unsigned ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int unsigned ROUNDS_B = ROUNDS_B_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           decrypt,
  input  logic           no_ad,
  input  logic [127:0]   key,
  input  logic [127:0]   nonce,
  input  logic           ad_valid,
  input  logic [63:0]    ad_data,
  input  logic           ad_last,
  output logic           ad_ready,
  input  logic           din_valid,
  input  logic [63:0]    din_data,
  input  logic           din_last,
  output logic           din_ready,
  output logic           dout_valid,
  output logic [63:0]    dout_data,
  input  logic [127:0]   tag_in,
  output logic           tag_valid,
  output logic [127:0]   tag,
  output logic           auth_ok,
  output logic           busy,
  output logic           perm_start,
  output logic [3:0]     perm_rnd,
  output logic [319:0]   perm_s_out,
  input  logic           perm_ready,
  input  logic [319:0]   perm_s_in
);

  aead_state_e          state_q, state_d;
  logic [STATE_W-1:0]   s_q, s_d;
  logic [127:0]         key_q, key_d;
  logic                 decrypt_q, decrypt_d;
  logic                 no_ad_q, no_ad_d;
  logic                 ad_last_q, ad_last_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [63:0]          dout_data_q, dout_data_d;

  logic                 call_req;
  logic [3:0]           call_rnd;
  logic                 call_done;
  logic [STATE_W-1:0]   call_s_in;
  logic                 ad_acc;
  logic                 din_acc;
  logic [63:0]          msg_word;
  logic [127:0]         tag_calc;

  ascon_aead_sequencer_perm_call u_perm_call (
    .clk        (clk),
    .reset      (reset),
    .req        (call_req),
    .rnd        (call_rnd),
    .s_out      (s_q),
    .done       (call_done),
    .s_in       (call_s_in),
    .perm_start (perm_start),
    .perm_rnd   (perm_rnd),
    .perm_s_out (perm_s_out),
    .perm_ready (perm_ready),
    .perm_s_in  (perm_s_in)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      s_q          <= '0;
      key_q        <= '0;
      decrypt_q    <= 1'b0;
      no_ad_q      <= 1'b0;
      ad_last_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      key_q        <= key_d;
      decrypt_q    <= decrypt_d;
      no_ad_q      <= no_ad_d;
      ad_last_q    <= ad_last_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  // Handshakes; readies are additionally masked by perm_start
  assign ad_ready  = (state_q == StAd) && !perm_start;
  assign din_ready = (state_q == StMsg) && !perm_start;
  assign ad_acc    = ad_valid & ad_ready;
  assign din_acc   = din_valid & din_ready;
  assign msg_word  = s_q[S0_MSB -: WORD_W] ^ din_data;
  assign tag_calc  = {s_q[S3_MSB -: WORD_W], s_q[S4_MSB -: WORD_W]} ^ key_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StInitP;
      StInitP: if (call_done) state_d = no_ad_q ? StDsep : StAd;
      StAd:    if (ad_acc) state_d = StAdP;
      StAdP:   if (call_done) state_d = ad_last_q ? StDsep : StAd;
      StDsep:  state_d = StMsg;
      StMsg:   if (din_acc) state_d = din_last ? StFinP : StMsgP;
      StMsgP:  if (call_done) state_d = StMsg;
      StFinP:  if (call_done) state_d = StTag;
      StTag:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    s_d          = s_q;
    key_d        = key_q;
    decrypt_d    = decrypt_q;
    no_ad_d      = no_ad_q;
    ad_last_d    = ad_last_q;
    dout_valid_d = 1'b0;
    dout_data_d  = dout_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          s_d       = {IV, key, nonce};
          key_d     = key;
          decrypt_d = decrypt;
          no_ad_d   = no_ad;
        end
      end
      StInitP: begin
        if (call_done) s_d = call_s_in ^ {192'b0, key_q};
      end
      StAd: begin
        if (ad_acc) begin
          s_d[S0_MSB -: WORD_W] = s_q[S0_MSB -: WORD_W] ^ ad_data;
          ad_last_d             = ad_last;
        end
      end
      StAdP, StMsgP, StFinP: begin
        if (call_done) s_d = call_s_in;
      end
      StDsep: begin
        s_d[0] = ~s_q[0];
      end
      StMsg: begin
        if (din_acc) begin
          dout_valid_d          = 1'b1;
          dout_data_d           = msg_word;
          s_d[S0_MSB -: WORD_W] = decrypt_q ? din_data : msg_word;
          // Final block: fold the key into S1/S2 ahead of the pa call
          if (din_last) begin
            s_d[S1_MSB -: WORD_W] = s_q[S1_MSB -: WORD_W] ^ key_q[127:64];
            s_d[S2_MSB -: WORD_W] = s_q[S2_MSB -: WORD_W] ^ key_q[63:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    call_req   = (state_q == StInitP) || (state_q == StAdP) ||
                 (state_q == StMsgP)  || (state_q == StFinP);
    call_rnd   = ((state_q == StInitP) || (state_q == StFinP)) ? 4'(ROUNDS_A) : 4'(ROUNDS_B);
    busy       = (state_q != StIdle);
    tag_valid  = (state_q == StTag);
    tag        = tag_valid ? tag_calc : '0;
    auth_ok    = tag_valid && (decrypt_q ? (tag_calc == tag_in) : 1'b1);
    dout_valid = dout_valid_q;
    dout_data  = dout_data_q;
  end

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Directed bench for ascon_aead_sequencer with a behavioural Ascon permutation
// core and an independent Ascon-128 reference model.
module tb_ascon_aead_sequencer;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0, decrypt = 1'b0, no_ad = 1'b0;
  logic [127:0]   key = '0, nonce = '0, tag_in = '0;
  logic           ad_valid = 1'b0, ad_last = 1'b0;
  logic [63:0]    ad_data = '0;
  logic           ad_ready;
  logic           din_valid = 1'b0, din_last = 1'b0;
  logic [63:0]    din_data = '0;
  logic           din_ready;
  logic           dout_valid;
  logic [63:0]    dout_data;
  logic           tag_valid, auth_ok, busy;
  logic [127:0]   tag;
  logic           perm_start;
  logic [3:0]     perm_rnd;
  logic [319:0]   perm_s_out;
  logic           perm_ready;
  logic [319:0]   perm_s_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  ad_blk [4];
  logic [63:0]  pt_blk [4];
  logic [63:0]  exp_dout [4];
  logic [127:0] exp_tag;
  logic         exp_auth;

  ascon_aead_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .decrypt    (decrypt),
    .no_ad      (no_ad),
    .key        (key),
    .nonce      (nonce),
    .ad_valid   (ad_valid),
    .ad_data    (ad_data),
    .ad_last    (ad_last),
    .ad_ready   (ad_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .tag_in     (tag_in),
    .tag_valid  (tag_valid),
    .tag        (tag),
    .auth_ok    (auth_ok),
    .busy       (busy),
    .perm_start (perm_start),
    .perm_rnd   (perm_rnd),
    .perm_s_out (perm_s_out),
    .perm_ready (perm_ready),
    .perm_s_in  (perm_s_in)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s, input logic [3:0] rnd);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 12 - int'(rnd); i < 12; i++) begin
      c  = {4'(15 - i), 4'(i)};
      x2 = x2 ^ {56'h0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // Behavioural core: ready after a (possibly random) delay, one cycle wide
  logic [3:0] rnd_log [64];
  int         rnd_n = 0;
  int         core_cnt = 0;
  int         core_delay = 0;
  bit         core_rand = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      perm_ready <= 1'b0;
      perm_s_in  <= '0;
      core_cnt   <= 0;
    end else if (perm_ready) begin
      perm_ready <= 1'b0;
    end else if (perm_start) begin
      if (core_cnt >= core_delay) begin
        perm_ready <= 1'b1;
        perm_s_in  <= ascon_p(perm_s_out, perm_rnd);
        if (rnd_n < 64) rnd_log[rnd_n] <= perm_rnd;
        rnd_n      <= rnd_n + 1;
        core_cnt   <= 0;
        core_delay <= core_rand ? int'($urandom_range(0, 20)) : 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  int dout_cnt = 0, tag_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (dout_valid) dout_cnt <= dout_cnt + 1;
    if (tag_valid) tag_cnt <= tag_cnt + 1;
    if (perm_start && (ad_ready || din_ready)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string name, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ":ctrl"}, {busy, perm_start, ad_ready, din_ready, dout_valid, tag_valid,
                            auth_ok}, 0);
    check({name, ":perm_rnd"}, perm_rnd, 0);
    check({name, ":perm_s_out"}, perm_s_out, 0);
    check({name, ":tag"}, tag, 0);
    check({name, ":dout_data"}, dout_data, 0);
  endtask

  task automatic ref_model(input bit dec, input bit noad, input logic [127:0] k,
                           input logic [127:0] n, input int nad, input int nmsg);
    logic [319:0] s;
    logic [63:0]  o;
    s = ascon_p({64'h80400c0600000000, k, n}, 4'd12);
    s[127:0] = s[127:0] ^ k;
    if (!noad) begin
      for (int i = 0; i < nad; i++) begin
        s[319:256] = s[319:256] ^ ad_blk[i];
        s = ascon_p(s, 4'd6);
      end
    end
    s[0] = ~s[0];
    for (int i = 0; i < nmsg; i++) begin
      o = s[319:256] ^ pt_blk[i];
      exp_dout[i] = o;
      s[319:256] = dec ? pt_blk[i] : o;
      if (i < nmsg - 1) s = ascon_p(s, 4'd6);
    end
    s[255:128] = s[255:128] ^ k;
    s = ascon_p(s, 4'd12);
    exp_tag = s[127:0] ^ k;
  endtask

  task automatic send_ad(input logic [63:0] d, input bit last, input bit rv);
    bit acc = 1'b0;
    int waited = 0;
    if (rv) repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    ad_data = d; ad_last = last; ad_valid = 1'b1;
    while (!acc && waited < 3000) begin
      @(negedge clk);
      if (rv) ad_valid = ($urandom_range(0, 2) != 0);
      if (ad_valid && ad_ready) acc = 1'b1;
      waited++;
    end
    check("ad_accept", acc, 1);
    @(posedge clk); #1;
    ad_valid = 1'b0; ad_last = 1'b0; ad_data = '0;
  endtask

  task automatic send_din(input string name, input int idx, input logic [63:0] d,
                          input bit last, input bit rv);
    bit acc = 1'b0;
    int waited = 0;
    if (rv) repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    din_data = d; din_last = last; din_valid = 1'b1;
    while (!acc && waited < 3000) begin
      @(negedge clk);
      if (rv) din_valid = ($urandom_range(0, 2) != 0);
      if (din_valid && din_ready) acc = 1'b1;
      waited++;
    end
    check({name, ":din_accept"}, acc, 1);
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0; din_data = '0;
    check({name, ":dout_valid"}, dout_valid, 1);
    check({name, ":dout_data"}, dout_data, exp_dout[idx]);
  endtask

  task automatic run_op(input string name, input bit dec, input bit noad,
                        input logic [127:0] k, input logic [127:0] n, input int nad,
                        input int nmsg, input logic [127:0] tin, input bit rv);
    int rbase, dbase, tbase, ncalls, waited;
    bit got = 1'b0;
    logic [127:0] obs_tag = '0;
    logic obs_auth = 1'b0;
    rbase = rnd_n; dbase = dout_cnt; tbase = tag_cnt;
    @(posedge clk); #1;
    decrypt = dec; no_ad = noad; key = k; nonce = n; tag_in = tin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":busy"}, busy, 1);
    // A second start with corrupted setup while busy must change nothing
    key = ~k; nonce = ~n; decrypt = ~dec; no_ad = ~noad; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!noad) for (int i = 0; i < nad; i++) send_ad(ad_blk[i], i == nad - 1, rv);
    for (int i = 0; i < nmsg; i++) send_din(name, i, pt_blk[i], i == nmsg - 1, rv);
    waited = 0;
    while (!got && waited < 3000) begin
      @(negedge clk);
      if (tag_valid) begin
        got = 1'b1; obs_tag = tag; obs_auth = auth_ok;
      end
      waited++;
    end
    check({name, ":tag_seen"}, got, 1);
    check({name, ":tag"}, obs_tag, exp_tag);
    check({name, ":auth_ok"}, obs_auth, exp_auth);
    @(negedge clk);
    check({name, ":idle_after"}, busy, 0);
    check({name, ":dout_pulses"}, dout_cnt - dbase, nmsg);
    check({name, ":tag_pulses"}, tag_cnt - tbase, 1);
    ncalls = 2 + (noad ? 0 : nad) + nmsg - 1;
    check({name, ":calls"}, rnd_n - rbase, ncalls);
    for (int j = 0; j < ncalls && rbase + j < 64; j++)
      check({name, $sformatf(":rnd%0d", j)}, rnd_log[rbase + j],
            (j == 0 || j == ncalls - 1) ? 12 : 6);
    decrypt = 1'b0; no_ad = 1'b0; key = '0; nonce = '0; tag_in = '0;
  endtask

  logic [127:0] k2, n2, tag2;
  logic [63:0]  pt2 [3];
  logic [63:0]  ct2 [3];

  initial begin
    int tbase, waited;
    bit got;
    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    n2 = 128'h101112131415161718191a1b1c1d1e1f;
    ad_blk[0] = 64'h4144303132333435; ad_blk[1] = 64'h4142438000000000;
    ad_blk[2] = '0; ad_blk[3] = '0;
    pt2[0] = 64'h0011223344556677; pt2[1] = 64'h8899aabbccddeeff;
    pt2[2] = 64'hdeadbe8000000000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // 1: no AD, single padding block, zero key/nonce
    pt_blk[0] = 64'h8000000000000000;
    ref_model(1'b0, 1'b1, '0, '0, 0, 1);
    exp_auth = 1'b1;
    run_op("t1", 1'b0, 1'b1, '0, '0, 0, 1, '0, 1'b0);

    // 2: two AD blocks, three message blocks
    for (int i = 0; i < 3; i++) pt_blk[i] = pt2[i];
    ref_model(1'b0, 1'b0, k2, n2, 2, 3);
    for (int i = 0; i < 3; i++) ct2[i] = exp_dout[i];
    tag2 = exp_tag;
    exp_auth = 1'b1;
    run_op("t2", 1'b0, 1'b0, k2, n2, 2, 3, '0, 1'b0);

    // 3: decrypt back, same tag, authentic
    for (int i = 0; i < 3; i++) begin
      pt_blk[i] = ct2[i]; exp_dout[i] = pt2[i];
    end
    exp_tag = tag2; exp_auth = 1'b1;
    run_op("t3", 1'b1, 1'b0, k2, n2, 2, 3, tag2, 1'b0);

    // 4: corrupted expected tag
    exp_auth = 1'b0;
    run_op("t4", 1'b1, 1'b0, k2, n2, 2, 3, tag2 ^ 128'h1, 1'b0);

    // 5: random valids and core latency, encrypt results unchanged
    core_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pt_blk[i] = pt2[i]; exp_dout[i] = ct2[i];
    end
    exp_tag = tag2; exp_auth = 1'b1;
    run_op("t5", 1'b0, 1'b0, k2, n2, 2, 3, '0, 1'b1);
    core_rand = 1'b0;

    // 6: reset during the second pb call, then rerun test 1
    tbase = tag_cnt;
    @(posedge clk); #1;
    key = k2; nonce = n2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_ad(ad_blk[0], 1'b0, 1'b0);
    send_ad(ad_blk[1], 1'b0, 1'b0);
    got = 1'b0; waited = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (perm_start && perm_rnd == 4'd6) got = 1'b1;
      waited++;
    end
    check("t6:second_pb", got, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("t6:abort");
    @(negedge clk);
    reset = 1'b0;
    check("t6:no_tag", tag_cnt - tbase, 0);
    key = '0; nonce = '0;
    pt_blk[0] = 64'h8000000000000000;
    ref_model(1'b0, 1'b1, '0, '0, 0, 1);
    exp_auth = 1'b1;
    run_op("t6", 1'b0, 1'b1, '0, '0, 0, 1, '0, 1'b0);

    check("ready_vs_perm_start", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
